// File: rtl/seq_divider_32.sv
// Multi-cycle restoring divider: one trial subtraction per cycle, start/done handshake.
// Optional signed support (div) is enabled by defining DIVIDER_SIGNED_EN.
module seq_divider_32 #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] dvsr_q, dvsr_d;
    logic             quo_neg_q, quo_neg_d;
    logic             rem_neg_q, rem_neg_d;
    logic [WIDTH-1:0] quotient_q, quotient_d;
    logic [WIDTH-1:0] remainder_q, remainder_d;
    logic             dbz_q, dbz_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic             op_signed_s;
    logic             a_neg_s, b_neg_s;
    logic [WIDTH-1:0] a_mag_s, b_mag_s;
    logic [WIDTH-1:0] shift_s;
    logic [WIDTH:0]   diff_s;
    logic             take_s;
    logic [WIDTH-1:0] rem_step_s, quo_step_s;
    logic [WIDTH-1:0] quo_fix_s, rem_fix_s;

`ifdef DIVIDER_SIGNED_EN
    assign op_signed_s = is_signed;
`else
    logic unused_is_signed_s;
    assign unused_is_signed_s = is_signed;
    assign op_signed_s        = 1'b0;
`endif

    // Operand magnitudes and sign flags at capture; zero flags in unsigned mode.
    always_comb begin
        a_neg_s = op_signed_s & dividend[WIDTH-1];
        b_neg_s = op_signed_s & divisor[WIDTH-1];
        a_mag_s = a_neg_s ? ({WIDTH{1'b0}} - dividend) : dividend;
        b_mag_s = b_neg_s ? ({WIDTH{1'b0}} - divisor) : divisor;
    end

    // One restoring step. A set remainder MSB means the shifted value exceeds any
    // divisor, so the subtraction is taken regardless of the borrow.
    always_comb begin
        shift_s    = {rem_q[WIDTH-2:0], quo_q[WIDTH-1]};
        diff_s     = {1'b0, shift_s} - {1'b0, dvsr_q};
        take_s     = rem_q[WIDTH-1] | ~diff_s[WIDTH];
        rem_step_s = take_s ? diff_s[WIDTH-1:0] : shift_s;
        quo_step_s = {quo_q[WIDTH-2:0], take_s};
        quo_fix_s  = quo_neg_q ? ({WIDTH{1'b0}} - quo_step_s) : quo_step_s;
        rem_fix_s  = rem_neg_q ? ({WIDTH{1'b0}} - rem_step_s) : rem_step_s;
    end

    // Next-state and datapath control.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rem_d       = rem_q;
        quo_d       = quo_q;
        dvsr_d      = dvsr_q;
        quo_neg_d   = quo_neg_q;
        rem_neg_d   = rem_neg_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        dbz_d       = dbz_q;
        busy_d      = 1'b0;
        done_d      = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (divisor == {WIDTH{1'b0}}) begin
                        state_d     = DONE;
                        quotient_d  = {WIDTH{1'b1}};
                        remainder_d = dividend;
                        dbz_d       = 1'b1;
                        done_d      = 1'b1;
                    end else begin
                        state_d   = RUN;
                        cnt_d     = CNT_LAST;
                        rem_d     = {WIDTH{1'b0}};
                        quo_d     = a_mag_s;
                        dvsr_d    = b_mag_s;
                        quo_neg_d = a_neg_s ^ b_neg_s;
                        rem_neg_d = a_neg_s;
                        busy_d    = 1'b1;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                rem_d = rem_step_s;
                quo_d = quo_step_s;
                if (cnt_q == {CW{1'b0}}) begin
                    state_d     = DONE;
                    quotient_d  = quo_fix_s;
                    remainder_d = rem_fix_s;
                    dbz_d       = 1'b0;
                    done_d      = 1'b1;
                end else begin
                    cnt_d  = cnt_q - CNT_ONE;
                    busy_d = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and result registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= {CW{1'b0}};
            rem_q       <= {WIDTH{1'b0}};
            quo_q       <= {WIDTH{1'b0}};
            dvsr_q      <= {WIDTH{1'b0}};
            quo_neg_q   <= 1'b0;
            rem_neg_q   <= 1'b0;
            quotient_q  <= {WIDTH{1'b0}};
            remainder_q <= {WIDTH{1'b0}};
            dbz_q       <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rem_q       <= rem_d;
            quo_q       <= quo_d;
            dvsr_q      <= dvsr_d;
            quo_neg_q   <= quo_neg_d;
            rem_neg_q   <= rem_neg_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            dbz_q       <= dbz_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_divider_32.sv
// Scoreboard bench for seq_divider_32: stimulus pushes expected results, a negedge
// monitor pops and checks them (values, latency, busy duration) on every done pulse.
module tb_seq_divider_32;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        is_signed;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        busy;
    logic        done;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic        div_by_zero;

    seq_divider_32 #(.WIDTH(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .is_signed  (is_signed),
        .dividend   (dividend),
        .divisor    (divisor),
        .busy       (busy),
        .done       (done),
        .quotient   (quotient),
        .remainder  (remainder),
        .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] q;
        logic [31:0] r;
        logic        dbz;
        int          acc;
        int          lat;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    int   busy_cnt = 0;

    // Edge counter: value k means k rising edges have occurred.
    always @(posedge clk) cyc = cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: done observed after edge E means it is high in the period after E;
    // start accepted at edge A gives E-A == 32 (or 0 for divide by zero).
    always @(negedge clk) begin
        if (rst_n !== 1'b1) begin
            busy_cnt = 0;
        end else if (done === 1'b1) begin
            if (sb.size() == 0) begin
                chk("unexpected_done", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("quotient", quotient, e.q);
                chk("remainder", remainder, e.r);
                chk("div_by_zero", {31'd0, div_by_zero}, {31'd0, e.dbz});
                chk("latency", cyc - e.acc, e.lat);
                chk("busy_cycles", busy_cnt, e.lat);
            end
            busy_cnt = 0;
        end else if (busy === 1'b1) begin
            busy_cnt = busy_cnt + 1;
        end
    end

    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                         input logic [31:0] eq, input logic [31:0] er, input logic edbz);
        exp_t e;
        @(negedge clk);
        start     = 1'b1;
        dividend  = a;
        divisor   = b;
        is_signed = sgn;
        e.q   = eq;
        e.r   = er;
        e.dbz = edbz;
        e.acc = cyc + 1;
        e.lat = edbz ? 0 : 32;
        sb.push_back(e);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (done !== 1'b1 && n < 100) begin
            @(negedge clk);
            n = n + 1;
        end
        checks = checks + 1;
        if (done !== 1'b1) begin
            errors = errors + 1;
            $display("FAIL done_timeout: got no done after %0d cycles expected done", n);
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        start     = 1'b0;
        is_signed = 1'b0;
        dividend  = 32'd0;
        divisor   = 32'd0;
        repeat (2) @(negedge clk);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_quotient", quotient, 32'd0);
        chk("rst_remainder", remainder, 32'd0);
        chk("rst_dbz", {31'd0, div_by_zero}, 32'd0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        chk("idle_busy", {31'd0, busy}, 32'd0);

        issue(32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 1'b0);
        wait_done();
        issue(32'hFFFF_FFFF, 32'd1, 1'b0, 32'hFFFF_FFFF, 32'd0, 1'b0);
        wait_done();
        issue(32'd5, 32'd9, 1'b0, 32'd0, 32'd5, 1'b0);
        wait_done();
        issue(32'hFFFF_FFFF, 32'h8000_0001, 1'b0, 32'd1, 32'h7FFF_FFFE, 1'b0);
        wait_done();
        issue(32'hFFFF_FFFE, 32'hFFFF_FFFF, 1'b0, 32'd0, 32'hFFFF_FFFE, 1'b0);
        wait_done();
        issue(32'h0000_1234, 32'd0, 1'b0, 32'hFFFF_FFFF, 32'h0000_1234, 1'b1);
        wait_done();
        issue(32'd1000, 32'd3, 1'b0, 32'd333, 32'd1, 1'b0);
        wait_done();

        // Start pulse and operand changes mid-RUN must be ignored.
        repeat (3) @(negedge clk);
        issue(32'd1000, 32'd3, 1'b0, 32'd333, 32'd1, 1'b0);
        repeat (5) @(negedge clk);
        start    = 1'b1;
        dividend = 32'd7;
        divisor  = 32'd0;
        @(negedge clk);
        start    = 1'b0;
        dividend = 32'd99;
        divisor  = 32'd5;
        wait_done();

`ifdef DIVIDER_SIGNED_EN
        issue(32'hFFFF_FFF9, 32'd2, 1'b1, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0);
        wait_done();
        issue(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 32'd0, 1'b0);
        wait_done();
        issue(32'd7, 32'hFFFF_FFFE, 1'b1, 32'hFFFF_FFFD, 32'd1, 1'b0);
        wait_done();
        issue(32'hFFFF_FFF9, 32'd0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 1'b1);
        wait_done();
`else
        issue(32'hFFFF_FFF9, 32'd2, 1'b1, 32'h7FFF_FFFC, 32'd1, 1'b0);
        wait_done();
        issue(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'd0, 32'h8000_0000, 1'b0);
        wait_done();
        issue(32'd7, 32'hFFFF_FFFE, 1'b1, 32'd0, 32'd7, 1'b0);
        wait_done();
`endif

        // Reset around RUN cycle 10 aborts with no result and no done pulse.
        issue(32'hDEAD_BEEF, 32'd3, 1'b0, 32'd0, 32'd0, 1'b0);
        repeat (8) @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        sb.delete();
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_done", {31'd0, done}, 32'd0);
        chk("abort_quotient", quotient, 32'd0);
        chk("abort_remainder", remainder, 32'd0);
        chk("abort_dbz", {31'd0, div_by_zero}, 32'd0);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);

        issue(32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 1'b0);
        wait_done();
        repeat (3) @(negedge clk);
        chk("scoreboard_empty", sb.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
